sram_1rw1r_ctrl: RTL and testbench
==================================

# sram_1rw1r_ctrl

Request/response front end for one 2048×32 1RW1R OpenRAM macro. Converts two valid/ready client ports into the macro's active-low chip-select/write-enable pins, captures read data one cycle after the macro clocks it out, and buffers responses in 2-entry FIFOs so client backpressure never loses data. It also blocks a port-1 read from the address port 0 is writing in the same cycle. Sits directly upstream of the macro; both macro clocks are tied to `clk`.

## Interface
- `ADDR_WIDTH`, 11, word address width
- `DATA_WIDTH`, 32, data width
- `NUM_WMASKS`, 4, byte-lane count (DATA_WIDTH/8)
- `RSP_DEPTH`, 2, response FIFO entries per port

- `clk`  in  1  single clock; also drives macro `clk0`/`clk1`
- `rst_n`  in  1  asynchronous, active-low reset
- `p0_req_valid` / `p0_req_ready`  in / out  1  port-0 request handshake
- `p0_req_we`  in  1  1 = write, 0 = read
- `p0_req_wmask`  in  NUM_WMASKS  byte enables (writes only)
- `p0_req_addr`  in  ADDR_WIDTH  word address
- `p0_req_wdata`  in  DATA_WIDTH  write data
- `p0_rsp_valid` / `p0_rsp_ready`  out / in  1  port-0 read-response handshake
- `p0_rsp_rdata`  out  DATA_WIDTH  read data
- `p1_req_valid` / `p1_req_ready`  in / out  1  port-1 (read-only) request handshake
- `p1_req_addr`  in  ADDR_WIDTH  word address
- `p1_rsp_valid` / `p1_rsp_ready` / `p1_rsp_rdata`  out / in / out  1 / 1 / DATA_WIDTH  port-1 response
- `sram_csb0`, `sram_web0`, `sram_wmask0`, `sram_addr0`, `sram_din0`  out  1, 1, NUM_WMASKS, ADDR_WIDTH, DATA_WIDTH  macro port-0 drive
- `sram_dout0`  in  DATA_WIDTH  macro port-0 read data
- `sram_csb1`, `sram_addr1`  out  1, ADDR_WIDTH  macro port-1 drive
- `sram_dout1`  in  DATA_WIDTH  macro port-1 read data

## Operation
- A request is accepted at posedge T when `valid & ready`. Macro pins are driven combinationally from the accepted request in the cycle before T, so the macro latches them at T.
- When no request is accepted: `sram_csb0`/`sram_csb1` = 1, `sram_web0` = 1, and the other macro outputs carry the client request fields as-is (don't-care).
- Port-0 write: `sram_web0` = 0; mask and data pass through. No response is generated. Writes need no FIFO credit.
- Reads (either port) set the port's `inflight` flag at T. At T+1 the macro's `dout` is captured into that port's response FIFO and `inflight` is cleared.
- Credit rule for a read: `req_ready = rst_n & (occ + inflight - pop) < RSP_DEPTH`, where `pop = rsp_valid & rsp_ready`. The FIFO therefore never overflows. For port 0 this gating applies only when `p0_req_we` = 0; writes are ready whenever `rst_n` = 1.
- Hazard: if a port-0 write is accepted this cycle to address A and `p1_req_addr` == A, then `p1_req_ready` = 0 for this cycle. The read is accepted the next cycle and returns the new data.
- No other cross-port ordering. A port-0 write at T followed by any read at T+1 or later returns the written bytes; unmasked bytes keep their old value.
- FIFO: `rsp_valid` = occ != 0; `rsp_rdata` = head entry. Push and pop in the same cycle are allowed at any occupancy from 0 to RSP_DEPTH.
- Reset (async, any time): `inflight` = 0, FIFOs emptied, all `req_ready` = 0, all `rsp_valid` = 0, `sram_csb0` = `sram_csb1` = 1, `sram_web0` = 1. A read in flight when reset asserts is dropped. Outputs are held at these values while `rst_n` is low.

## Timing
- Read latency: request accepted at T → `rsp_valid` high in the cycle after T+1. This is 2 cycles when the FIFO is empty.
- Sustained throughput: 1 read per cycle per port while the client holds `rsp_ready` = 1.
- If `rsp_ready` is held at 0, at most RSP_DEPTH reads are accepted before `req_ready` falls.
- Combinational paths: `rsp_ready` → `req_ready`; `req_*` → `sram_*`. All other outputs are registered.

## Structure
- Package `sram_ctrl_pkg`: `ADDR_WIDTH`, `DATA_WIDTH`, `NUM_WMASKS`, `RSP_DEPTH` defaults and `addr_t`/`data_t`/`wmask_t` typedefs.
- Sub-module `sram_rsp_fifo`: RSP_DEPTH-entry FIFO with occupancy output, instantiated once per port.
- The top level holds the inflight flags, credit logic, hazard compare and macro pin drive.

## Test plan
- Write 0xDEADBEEF, mask 4'b1111, to addr 0x005; then p0 read 0x005 → `p0_rsp_rdata` = 0xDEADBEEF two cycles after acceptance.
- Write 0x11223344 to 0x010; then write 0xAABBCCDD with mask 4'b0101 → read 0x010 returns 0x11BB33DD.
- Same cycle: p0 writes 0x7FF = 0xCAFEF00D while p1 reads 0x7FF → `p1_req_ready` = 0 that cycle; read accepted next cycle and returns 0xCAFEF00D.
- Hold `p1_rsp_ready` = 0 and issue 4 back-to-back p1 reads → exactly 2 accepted. Release `rsp_ready` → data returned in order, remaining reads then accepted.
- p0 and p1 each stream 16 reads with `rsp_ready` = 1 → one accept per cycle per port, no stalls, data matches a scoreboard.
- Assert `rst_n` low one cycle after a read is accepted → `rsp_valid` = 0, `csb` = 1, `req_ready` = 0 immediately. After release the stale read never appears, and a new read 0x005 returns the pre-reset memory contents.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared defaults and types for the 1RW1R SRAM front end.
//   ADDR_WIDTH/DATA_WIDTH/NUM_WMASKS describe the 2048x32 OpenRAM macro;
//   RSP_DEPTH is the per-port response FIFO depth.
//   credit_ok() is the read-admission rule used by both ports.
package sram_ctrl_pkg;

  localparam int ADDR_WIDTH = 11;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;
  localparam int RSP_DEPTH  = 2;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [NUM_WMASKS-1:0] wmask_t;

  // A read may be admitted when the entries already held, plus the one
  // still coming back from the macro, minus the one leaving this cycle,
  // leave room in the FIFO. occ + inflight >= pop always holds because a
  // pop needs a valid (non-empty) FIFO.
  function automatic logic credit_ok(input int occ, input logic inflight,
                                     input logic pop, input int depth);
    return (occ + int'(inflight) - int'(pop)) < depth;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo
//   Small circular response FIFO. Push and pop may happen in the same cycle
//   at any occupancy, including full (the popped head slot is reused).
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     push, push_data   write one entry
//     pop               remove head entry (caller only pops when valid)
//     valid, rdata      head entry present / head data
//     occ               current number of entries
module sram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic [OCC_W-1:0] occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [OCC_W-1:0] count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only observed after
  // it has been written, and leaving it unreset keeps it a plain RAM array.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign valid = (count != '0);
  assign rdata = mem[rd_ptr];
  assign occ   = count;

endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// sram_1rw1r_ctrl
//   Valid/ready front end for one 2048x32 1RW1R OpenRAM macro.
//   Port 0 reads or writes (byte-masked); port 1 only reads. Macro pins are
//   driven combinationally from the request accepted this cycle; read data
//   is captured one cycle after the macro clocks it and queued per port.
//   Ports:
//     clk, rst_n                          clock (also macro clk0/clk1), async reset
//     p0_req_* / p0_rsp_*                 port-0 request / read response
//     p1_req_* / p1_rsp_*                 port-1 read request / response
//     sram_csb0/web0/wmask0/addr0/din0    macro port-0 drive, sram_dout0 back
//     sram_csb1/addr1                     macro port-1 drive, sram_dout1 back
module sram_1rw1r_ctrl #(
  parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS = sram_ctrl_pkg::NUM_WMASKS,
  parameter int RSP_DEPTH  = sram_ctrl_pkg::RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [NUM_WMASKS-1:0] p0_req_wmask,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  import sram_ctrl_pkg::*;

  localparam int OCC_W = $clog2(RSP_DEPTH + 1);

  logic             p0_inflight, p1_inflight;
  logic [OCC_W-1:0] p0_occ, p1_occ;
  logic             p0_pop, p1_pop;
  logic             p0_credit, p1_credit;
  logic             p0_accept, p0_wr, p0_rd, p1_rd;
  logic             hazard;

  assign p0_pop = p0_rsp_valid & p0_rsp_ready;
  assign p1_pop = p1_rsp_valid & p1_rsp_ready;

  assign p0_credit = credit_ok(int'(p0_occ), p0_inflight, p0_pop, RSP_DEPTH);
  assign p1_credit = credit_ok(int'(p1_occ), p1_inflight, p1_pop, RSP_DEPTH);

  // Writes return nothing, so they bypass the credit check.
  assign p0_req_ready = rst_n & (p0_req_we | p0_credit);
  assign p0_accept    = p0_req_valid & p0_req_ready;
  assign p0_wr        = p0_accept & p0_req_we;
  assign p0_rd        = p0_accept & ~p0_req_we;

  // The macro gives undefined data when port 1 reads the word port 0 writes
  // in the same cycle; stall port 1 one cycle so it sees the new data.
  assign hazard       = p0_wr & (p1_req_addr == p0_req_addr);
  assign p1_req_ready = rst_n & p1_credit & ~hazard;
  assign p1_rd        = p1_req_valid & p1_req_ready;

  assign sram_csb0   = ~p0_accept;
  assign sram_web0   = ~p0_wr;
  assign sram_wmask0 = p0_req_wmask;
  assign sram_addr0  = p0_req_addr;
  assign sram_din0   = p0_req_wdata;
  assign sram_csb1   = ~p1_rd;
  assign sram_addr1  = p1_req_addr;

  // One-cycle marker: the macro output is valid the cycle after the read
  // was latched, at which point it is pushed into the response FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_inflight <= 1'b0;
      p1_inflight <= 1'b0;
    end else begin
      p0_inflight <= p0_rd;
      p1_inflight <= p1_rd;
    end
  end

  sram_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_WIDTH), .OCC_W(OCC_W)) u_p0_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (p0_inflight),
    .push_data (sram_dout0),
    .pop       (p0_pop),
    .valid     (p0_rsp_valid),
    .rdata     (p0_rsp_rdata),
    .occ       (p0_occ)
  );

  sram_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_WIDTH), .OCC_W(OCC_W)) u_p1_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (p1_inflight),
    .push_data (sram_dout1),
    .pop       (p1_pop),
    .valid     (p1_rsp_valid),
    .rdata     (p1_rsp_rdata),
    .occ       (p1_occ)
  );

endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// tb_sram_1rw1r_ctrl
//   Bench for sram_1rw1r_ctrl with a behavioural 1RW1R macro model.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_sram_1rw1r_ctrl;
  import sram_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   p0_req_valid, p0_req_ready, p0_req_we;
  wmask_t p0_req_wmask;
  addr_t  p0_req_addr;
  data_t  p0_req_wdata;
  logic   p0_rsp_valid, p0_rsp_ready;
  data_t  p0_rsp_rdata;
  logic   p1_req_valid, p1_req_ready;
  addr_t  p1_req_addr;
  logic   p1_rsp_valid, p1_rsp_ready;
  data_t  p1_rsp_rdata;
  logic   sram_csb0, sram_web0, sram_csb1;
  wmask_t sram_wmask0;
  addr_t  sram_addr0, sram_addr1;
  data_t  sram_din0, sram_dout0, sram_dout1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_1rw1r_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_req_valid (p0_req_valid),
    .p0_req_ready (p0_req_ready),
    .p0_req_we    (p0_req_we),
    .p0_req_wmask (p0_req_wmask),
    .p0_req_addr  (p0_req_addr),
    .p0_req_wdata (p0_req_wdata),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_ready (p0_rsp_ready),
    .p0_rsp_rdata (p0_rsp_rdata),
    .p1_req_valid (p1_req_valid),
    .p1_req_ready (p1_req_ready),
    .p1_req_addr  (p1_req_addr),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_ready (p1_rsp_ready),
    .p1_rsp_rdata (p1_rsp_rdata),
    .sram_csb0    (sram_csb0),
    .sram_web0    (sram_web0),
    .sram_wmask0  (sram_wmask0),
    .sram_addr0   (sram_addr0),
    .sram_din0    (sram_din0),
    .sram_dout0   (sram_dout0),
    .sram_csb1    (sram_csb1),
    .sram_addr1   (sram_addr1),
    .sram_dout1   (sram_dout1)
  );

  // Macro model: pins latched at the rising edge, dout valid until the next
  // read. Words never written read back as init_word(addr).
  data_t       mem [0:(1<<ADDR_WIDTH)-1];
  logic [(1<<ADDR_WIDTH)-1:0] written = '0;
  data_t       cur;

  function automatic data_t init_word(input addr_t a);
    return 32'hC0DE0000 | {21'd0, a};
  endfunction

  function automatic data_t peek(input addr_t a);
    return written[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        cur = peek(sram_addr0);
        for (int b = 0; b < NUM_WMASKS; b++)
          if (sram_wmask0[b]) cur[8*b +: 8] = sram_din0[8*b +: 8];
        mem[sram_addr0]     <= cur;
        written[sram_addr0] <= 1'b1;
      end else begin
        sram_dout0 <= peek(sram_addr0);
      end
    end
    if (!sram_csb1) sram_dout1 <= peek(sram_addr1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_wmask = '0;
    p0_req_addr = '0; p0_req_wdata = '0;
    p1_req_valid = 1'b0; p1_req_addr = '0;
  endtask

  typedef struct {
    logic   p0_valid; logic p0_we; wmask_t p0_wmask; addr_t p0_addr; data_t p0_wdata;
    logic   p1_valid; addr_t p1_addr;
    logic   exp_p0_ready; logic exp_p1_ready;
    logic   exp_csb0; logic exp_web0; logic exp_csb1;
    logic   exp_p0_rv; data_t exp_p0_rd;
    logic   exp_p1_rv; data_t exp_p1_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int acc, got, cyc;
    int issued0, issued1, got0, got1, stall0, stall1;

    // full write, masked overwrite, reads back, and the same-address hazard
    vecs[0] = '{1, 1, 4'hF, 11'h005, 32'hDEADBEEF, 0, 11'h000, 1, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[1] = '{1, 1, 4'hF, 11'h010, 32'h11223344, 0, 11'h000, 1, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[2] = '{1, 1, 4'h5, 11'h010, 32'hAABBCCDD, 0, 11'h000, 1, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[3] = '{1, 0, 4'h0, 11'h005, 32'h0,        0, 11'h000, 1, 1, 0, 1, 1, 0, 0, 0, 0};
    vecs[4] = '{1, 0, 4'h0, 11'h010, 32'h0,        0, 11'h000, 1, 1, 0, 1, 1, 0, 0, 0, 0};
    vecs[5] = '{1, 1, 4'hF, 11'h7FF, 32'hCAFEF00D, 1, 11'h7FF, 1, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0};
    vecs[6] = '{0, 0, 4'h0, 11'h000, 32'h0,        1, 11'h7FF, 1, 1, 1, 1, 0, 1, 32'h11BB33DD, 0, 0};
    vecs[7] = '{0, 0, 4'h0, 11'h000, 32'h0,        0, 11'h000, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    vecs[8] = '{0, 0, 4'h0, 11'h000, 32'h0,        0, 11'h000, 1, 1, 1, 1, 1, 0, 0, 1, 32'hCAFEF00D};
    vecs[9] = '{0, 0, 4'h0, 11'h000, 32'h0,        0, 11'h000, 1, 1, 1, 1, 1, 0, 0, 0, 0};

    idle();
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;

    // reset state, with requests offered to show they are ignored
    repeat (2) @(negedge clk);
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    #1;
    check("rst_p0_req_ready", p0_req_ready, 0);
    check("rst_p1_req_ready", p1_req_ready, 0);
    check("rst_p0_rsp_valid", p0_rsp_valid, 0);
    check("rst_p1_rsp_valid", p1_rsp_valid, 0);
    check("rst_csb0", sram_csb0, 1);
    check("rst_web0", sram_web0, 1);
    check("rst_csb1", sram_csb1, 1);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // table-driven cycle vectors
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      p0_req_valid = vecs[i].p0_valid; p0_req_we = vecs[i].p0_we;
      p0_req_wmask = vecs[i].p0_wmask; p0_req_addr = vecs[i].p0_addr;
      p0_req_wdata = vecs[i].p0_wdata;
      p1_req_valid = vecs[i].p1_valid; p1_req_addr = vecs[i].p1_addr;
      #1;
      check($sformatf("v%0d_p0_req_ready", i), p0_req_ready, vecs[i].exp_p0_ready);
      check($sformatf("v%0d_p1_req_ready", i), p1_req_ready, vecs[i].exp_p1_ready);
      check($sformatf("v%0d_csb0", i), sram_csb0, vecs[i].exp_csb0);
      check($sformatf("v%0d_web0", i), sram_web0, vecs[i].exp_web0);
      check($sformatf("v%0d_csb1", i), sram_csb1, vecs[i].exp_csb1);
      check($sformatf("v%0d_p0_rsp_valid", i), p0_rsp_valid, vecs[i].exp_p0_rv);
      check($sformatf("v%0d_p1_rsp_valid", i), p1_rsp_valid, vecs[i].exp_p1_rv);
      if (vecs[i].exp_p0_rv) check($sformatf("v%0d_p0_rdata", i), p0_rsp_rdata, vecs[i].exp_p0_rd);
      if (vecs[i].exp_p1_rv) check($sformatf("v%0d_p1_rdata", i), p1_rsp_rdata, vecs[i].exp_p1_rd);
    end

    // backpressure: 4 reads offered with p1_rsp_ready low, only 2 admitted
    acc = 0;
    @(negedge clk);
    idle();
    p1_rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      p1_req_valid = 1'b1;
      p1_req_addr  = 11'h020 + addr_t'(acc);
      #1;
      if (p1_req_ready) acc++;
    end
    check("bp_accepted_while_stalled", acc, 2);
    check("bp_req_ready_low", p1_req_ready, 0);
    check("bp_head_valid", p1_rsp_valid, 1);
    check("bp_head_data", p1_rsp_rdata, init_word(11'h020));
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 20) begin
      @(negedge clk);
      p1_rsp_ready = 1'b1;
      p1_req_valid = (acc < 4);
      p1_req_addr  = 11'h020 + addr_t'(acc);
      #1;
      if (p1_rsp_valid) begin
        check($sformatf("bp_rdata_%0d", got), p1_rsp_rdata, init_word(11'h020 + addr_t'(got)));
        got++;
      end
      if (p1_req_valid && p1_req_ready) acc++;
      cyc++;
    end
    check("bp_total_accepted", acc, 4);
    check("bp_total_returned", got, 4);

    // streaming: 16 reads per port, both ports every cycle
    @(negedge clk);
    idle();
    issued0 = 0; issued1 = 0; got0 = 0; got1 = 0; stall0 = 0; stall1 = 0;
    cyc = 0;
    while ((got0 < 16 || got1 < 16) && cyc < 40) begin
      @(negedge clk);
      p0_req_valid = (issued0 < 16); p0_req_we = 1'b0;
      p0_req_addr  = 11'h100 + addr_t'(issued0);
      p1_req_valid = (issued1 < 16);
      p1_req_addr  = 11'h200 + addr_t'(issued1);
      #1;
      if (p0_req_valid) begin
        if (p0_req_ready) issued0++; else stall0++;
      end
      if (p1_req_valid) begin
        if (p1_req_ready) issued1++; else stall1++;
      end
      if (p0_rsp_valid) begin
        check($sformatf("st_p0_rdata_%0d", got0), p0_rsp_rdata, init_word(11'h100 + addr_t'(got0)));
        got0++;
      end
      if (p1_rsp_valid) begin
        check($sformatf("st_p1_rdata_%0d", got1), p1_rsp_rdata, init_word(11'h200 + addr_t'(got1)));
        got1++;
      end
      cyc++;
    end
    check("st_p0_stalls", stall0, 0);
    check("st_p1_stalls", stall1, 0);
    check("st_p0_returned", got0, 16);
    check("st_p1_returned", got1, 16);

    // reset while a read is in flight
    @(negedge clk);
    idle();
    p0_req_valid = 1'b1; p0_req_addr = 11'h005;
    #1;
    check("rr_read_ready", p0_req_ready, 1);
    @(negedge clk);
    rst_n = 1'b0;
    p1_req_valid = 1'b1;
    #1;
    check("rr_p0_rsp_valid", p0_rsp_valid, 0);
    check("rr_p1_rsp_valid", p1_rsp_valid, 0);
    check("rr_csb0", sram_csb0, 1);
    check("rr_csb1", sram_csb1, 1);
    check("rr_web0", sram_web0, 1);
    check("rr_p0_req_ready", p0_req_ready, 0);
    check("rr_p1_req_ready", p1_req_ready, 0);
    repeat (2) @(negedge clk);
    idle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("rr_no_stale_%0d", c), p0_rsp_valid, 0);
    end
    @(negedge clk);
    p0_req_valid = 1'b1; p0_req_addr = 11'h005;
    #1;
    check("rr_new_read_ready", p0_req_ready, 1);
    cyc = 0;
    do begin
      @(negedge clk);
      idle();
      #1;
      cyc++;
    end while (!p0_rsp_valid && cyc < 8);
    check("rr_latency", cyc, 2);
    check("rr_rdata", p0_rsp_rdata, 32'hDEADBEEF);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
